// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use scoreboard, multi-cycle jump flush, multi-cycle EX freeze FSM and stall counter.
module hazard_control_unit #(
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_RegisterRd,
  input  logic [4:0]       IFID_Register1,
  input  logic [4:0]       IFID_Register2,
  input  logic             IFID_UsesRs1,
  input  logic             IFID_UsesRs2,
  input  logic             Jump,
  input  logic             MC_Start,
  input  logic             MC_Done,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             Bolha,
  output logic             Flush,
  output logic             MC_Timeout,
  output logic [CNT_W-1:0] StallCycles
);
  typedef enum logic {RUN, MC_WAIT} state_t;
  localparam int SBN = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 1 : 1;
  localparam int TW = $clog2(MC_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_SAT = TW'(MC_TIMEOUT);
  localparam logic [TW-1:0] TO_M1 = TW'(MC_TIMEOUT - 1);
  state_t state, state_next;
  logic [SBN-1:0] sb_v;
  logic [4:0] sb_rd [SBN];
  logic [2:0] fcnt;
  logic [TW-1:0] tcnt;
  logic hit1, hit2, live1, live2, lu, rec;
  always_comb begin
    hit1 = IDEX_MemRead && IDEX_RegisterRd == IFID_Register1;
    hit2 = IDEX_MemRead && IDEX_RegisterRd == IFID_Register2;
    for (int i = 0; i < SBN; i++) begin
      hit1 = hit1 || (sb_v[i] && sb_rd[i] == IFID_Register1);
      hit2 = hit2 || (sb_v[i] && sb_rd[i] == IFID_Register2);
    end
  end
  assign live1 = IFID_UsesRs1 && IFID_Register1 != 5'd0;
  assign live2 = IFID_UsesRs2 && IFID_Register2 != 5'd0;
  assign lu = (live1 && hit1) || (live2 && hit2);
  always_comb begin
    PCWrite = 1'b1;
    IFIDWrite = 1'b1;
    IDEXWrite = 1'b1;
    Bolha = 1'b0;
    Flush = 1'b0;
    state_next = state;
    if (!reset && state == RUN) begin
      Flush = Jump || fcnt != 3'd0;
      Bolha = lu && !Flush && !MC_Start;
      PCWrite = !Bolha;
      IFIDWrite = !Bolha;
      state_next = (MC_Start && !Jump) ? MC_WAIT : RUN;
    end else if (!reset) begin
      PCWrite = 1'b0;
      IFIDWrite = 1'b0;
      IDEXWrite = 1'b0;
      state_next = MC_Done ? RUN : MC_WAIT;
    end
  end
  // wrong-path or bubbled loads never reach the data path, so they are not tracked
  assign rec = IDEX_MemRead && IDEX_RegisterRd != 5'd0 && !Flush && !Bolha && state == RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      sb_v <= '0;
      fcnt <= '0;
      tcnt <= '0;
      MC_Timeout <= 1'b0;
      StallCycles <= '0;
    end else begin
      state <= state_next;
      if (state == RUN) begin
        for (int i = SBN - 1; i > 0; i--) begin
          sb_v[i] <= sb_v[i-1];
          sb_rd[i] <= sb_rd[i-1];
        end
        sb_v[0] <= rec && (LOAD_LATENCY > 1);
        sb_rd[0] <= IDEX_RegisterRd;
        fcnt <= Jump ? 3'(FLUSH_DEPTH - 1) : (fcnt != 3'd0 ? fcnt - 3'd1 : fcnt);
      end else begin
        tcnt <= MC_Done ? '0 : (tcnt == TO_SAT ? tcnt : tcnt + 1'b1);
        if (tcnt >= TO_M1) MC_Timeout <= 1'b1;
      end
      if (!PCWrite && !(&StallCycles)) StallCycles <= StallCycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: two parameterisations driven by shared stimulus, checked by a scoreboard against a reference model.
module tb_hazard_control_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, mr, j, ms, md, u1, u2;
  logic [4:0] rd, r1, r2;
  logic pcw [2], ifw [2], idw [2], bol [2], fl [2], tof_o [2];
  logic [15:0] sc0;
  logic [3:0] sc1;
  hazard_control_unit #(.LOAD_LATENCY(1), .FLUSH_DEPTH(1), .MC_TIMEOUT(64), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .IDEX_MemRead(mr), .IDEX_RegisterRd(rd),
    .IFID_Register1(r1), .IFID_Register2(r2), .IFID_UsesRs1(u1), .IFID_UsesRs2(u2),
    .Jump(j), .MC_Start(ms), .MC_Done(md), .PCWrite(pcw[0]), .IFIDWrite(ifw[0]),
    .IDEXWrite(idw[0]), .Bolha(bol[0]), .Flush(fl[0]), .MC_Timeout(tof_o[0]), .StallCycles(sc0));
  hazard_control_unit #(.LOAD_LATENCY(3), .FLUSH_DEPTH(3), .MC_TIMEOUT(8), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .IDEX_MemRead(mr), .IDEX_RegisterRd(rd),
    .IFID_Register1(r1), .IFID_Register2(r2), .IFID_UsesRs1(u1), .IFID_UsesRs2(u2),
    .Jump(j), .MC_Start(ms), .MC_Done(md), .PCWrite(pcw[1]), .IFIDWrite(ifw[1]),
    .IDEXWrite(idw[1]), .Bolha(bol[1]), .Flush(fl[1]), .MC_Timeout(tof_o[1]), .StallCycles(sc1));
  typedef struct {
    logic pc, ifid, idex, bol, fl, to;
    int sc;
  } exp_t;
  exp_t q0 [$], q1 [$];
  int checks = 0, errors = 0;
  int ll [2] = '{1, 3};
  int fd [2] = '{1, 3};
  int tmo [2] = '{64, 8};
  int cw [2] = '{16, 4};
  int rc [2], fu [2], wc [2], sc [2];
  bit inw [2], tf [2];
  int hist [2][8];
  // a load is a hazard for the RUN cycles whose age since its recording is 1..LOAD_LATENCY-1
  function automatic bit hz(int k, logic m, logic [4:0] d, logic [4:0] src);
    if (m && d == src) return 1'b1;
    for (int a = 1; a < ll[k]; a++)
      if (hist[k][(rc[k] - a) & 7] == int'(src)) return 1'b1;
    return 1'b0;
  endfunction
  function automatic exp_t step(int k, logic rs, logic m, logic [4:0] d, logic [4:0] a, logic [4:0] b,
                                logic ua, logic ub, logic jj, logic s, logic dn);
    exp_t e;
    bit lu;
    e.to = tf[k];
    e.sc = sc[k];
    e.pc = 1'b1; e.ifid = 1'b1; e.idex = 1'b1; e.bol = 1'b0; e.fl = 1'b0;
    if (rs) begin
      rc[k] = 0; fu[k] = -1; wc[k] = 0; sc[k] = 0; inw[k] = 1'b0; tf[k] = 1'b0;
      for (int i = 0; i < 8; i++) hist[k][i] = 0;
      return e;
    end
    if (!inw[k]) begin
      lu = (ua && a != 0 && hz(k, m, d, a)) || (ub && b != 0 && hz(k, m, d, b));
      e.fl = jj || rc[k] <= fu[k];
      e.bol = lu && !e.fl && !s;
      e.pc = !e.bol;
      e.ifid = !e.bol;
      hist[k][rc[k] & 7] = (m && d != 0 && !e.fl && !e.bol) ? int'(d) : 0;
      if (jj) fu[k] = rc[k] + fd[k] - 1;
      rc[k]++;
      if (s && !jj) begin inw[k] = 1'b1; wc[k] = 0; end
    end else begin
      e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b0;
      wc[k]++;
      if (wc[k] >= tmo[k]) tf[k] = 1'b1;
      if (dn) inw[k] = 1'b0;
    end
    if (!e.pc && sc[k] < (1 << cw[k]) - 1) sc[k]++;
    return e;
  endfunction
  task automatic drive(input logic rs, m, input logic [4:0] d, a, b, input logic ua, ub, jj, s, dn);
    @(posedge clk);
    #2;
    reset = rs; mr = m; rd = d; r1 = a; r2 = b; u1 = ua; u2 = ub; j = jj; ms = s; md = dn;
    assert (rs || !(inw[0] && (jj || s))) else $error("protocol violation: Jump/MC_Start during MC_WAIT");
    q0.push_back(step(0, rs, m, d, a, b, ua, ub, jj, s, dn));
    q1.push_back(step(1, rs, m, d, a, b, ua, ub, jj, s, dn));
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cmp(int k, string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[dut%0d] got=%0h exp=%0h t=%0t", n, k, got, want, $time);
    end
  endtask
  task automatic chk(int k, exp_t e);
    cmp(k, "PCWrite", 32'(pcw[k]), 32'(e.pc));
    cmp(k, "IFIDWrite", 32'(ifw[k]), 32'(e.ifid));
    cmp(k, "IDEXWrite", 32'(idw[k]), 32'(e.idex));
    cmp(k, "Bolha", 32'(bol[k]), 32'(e.bol));
    cmp(k, "Flush", 32'(fl[k]), 32'(e.fl));
    cmp(k, "MC_Timeout", 32'(tof_o[k]), 32'(e.to));
    cmp(k, "StallCycles", k == 0 ? 32'(sc0) : 32'(sc1), e.sc);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() != 0) chk(0, q0.pop_front());
      if (q1.size() != 0) chk(1, q1.pop_front());
    end
  end
  initial begin
    logic rs, jj, s, dn;
    reset = 1'b1; mr = 1'b0; rd = '0; r1 = '0; r2 = '0; u1 = 1'b0; u2 = 1'b0; j = 1'b0; ms = 1'b0; md = 1'b0;
    repeat (2) @(posedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) idle();
    drive(0, 1, 5, 0, 5, 0, 1, 0, 0, 0);
    idle();
    drive(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drive(0, 0, 0, 7, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    idle();
    drive(0, 1, 3, 3, 0, 1, 0, 1, 0, 0);
    drive(0, 1, 3, 3, 0, 1, 0, 1, 0, 0);
    repeat (3) drive(0, 1, 3, 3, 0, 1, 0, 0, 0, 0);
    idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (9) idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (12) idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (20) drive(0, 1, 9, 9, 0, 1, 0, 0, 0, 0);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rs = $urandom_range(0, 199) == 0;
      jj = !inw[0] && $urandom_range(0, 9) == 0;
      s = !inw[0] && $urandom_range(0, 24) == 0;
      dn = $urandom_range(0, 5) == 0;
      drive(rs, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, jj, s, dn);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
